serial_subtractor: RTL

- Bit-serial unsigned subtractor. It computes D = A - B one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- It is the inverse-direction companion to the team's 4-bit ripple-carry adder. It trades WIDTH cycles of latency for one arithmetic cell.
- It sits behind a start/busy/done handshake, so a controller FSM can launch operations and collect results.

---
 rtl/sub_pkg.sv | 18 +
 rtl/full_sub.sv | 23 ++
 rtl/serial_subtractor.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared types and constants for the serial subtractor
//
// Purpose: controller state encoding and default operand width used by
// serial_subtractor and its bench.
// Contents:
//   state_t        IDLE / SHIFT / DONE, 2-bit encoding
//   DEFAULT_WIDTH  operand and result width when not overridden
package sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub.sv
// rtl/full_sub.sv - combinational 1-bit full subtractor cell
//
// Purpose: computes one bit of A - B - Bi.
// Ports:
//   A   input   minuend bit
//   B   input   subtrahend bit
//   Bi  input   borrow in
//   D   output  difference bit
//   Bo  output  borrow out
module full_sub (
  input  logic A,
  input  logic B,
  input  logic Bi,
  output logic D,
  output logic Bo
);

  assign D  = A ^ B ^ Bi;
  // Borrow when the minuend bit is 0 and the subtrahend bit is 1, or when
  // the two bits are equal and a borrow is already pending.
  assign Bo = (~A & B) | (~(A ^ B) & Bi);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor with start/busy/done handshake
//
// Purpose: computes D = A - B one bit per clock, LSB first, through a single
// full_sub cell and a registered borrow. Result appears WIDTH cycles after
// the accepting edge.
// Ports:
//   clk    input          rising-edge clock
//   rst_n  input          asynchronous active-low reset
//   start  input          request a subtraction (ignored while busy)
//   A      input  [W-1:0] minuend, captured on the accepting edge
//   B      input  [W-1:0] subtrahend, captured on the accepting edge
//   D      output [W-1:0] registered difference, (A - B) mod 2^W
//   Bo     output         registered borrow out, 1 iff A < B
//   busy   output         high while shifting
//   done   output         one-cycle pulse when D/Bo show a new result
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic             Bo,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  // Only WIDTH-1 partial bits ever need holding: the final bit goes straight
  // from the cell into the result register.
  logic [WIDTH-2:0] d_sr_q, d_sr_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bo_q, bo_d;

  logic cell_diff;
  logic cell_bout;

  full_sub u_full_sub (
    .A  (a_sr_q[0]),
    .B  (b_sr_q[0]),
    .Bi (borrow_q),
    .D  (cell_diff),
    .Bo (cell_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    d_sr_d   = d_sr_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    d_d      = d_q;
    bo_d     = bo_q;
    busy     = 1'b0;
    done     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new start exactly like IDLE, giving back-to-back ops.
        done    = (state_q == DONE);
        state_d = IDLE;
        if (start) begin
          a_sr_d   = A;
          b_sr_d   = B;
          d_sr_d   = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        busy     = 1'b1;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        // New bit enters at the MSB end; the oldest bit moves toward bit 0.
        d_sr_d   = (WIDTH-1)'({cell_diff, d_sr_q} >> 1);
        borrow_d = cell_bout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          d_d     = {cell_diff, d_sr_q};
          bo_d    = cell_bout;
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      d_sr_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      d_q      <= '0;
      bo_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      d_sr_q   <= d_sr_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      d_q      <= d_d;
      bo_q     <= bo_d;
    end
  end

  assign D  = d_q;
  assign Bo = bo_q;

endmodule
